// File: rtl/switch_nport.sv
// Address-routed 1-to-N packet switch. The top address bits pick an output port,
// and each port has its own show-ahead FIFO. The switch either backpressures or drops on full.
module switch_nport_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         vld_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          pop;

  assign pop    = pop_i && (cnt_q != '0);
  assign full_o = (cnt_q == FULL_CNT);
  assign vld_o  = (cnt_q != '0);
  assign head_o = head_q;

  // Head is registered so the port holds its last value once the FIFO drains.
  always_comb begin
    wr_d   = wr_q + AW'(push_i);
    rd_d   = rd_q + AW'(pop);
    cnt_d  = cnt_q + CW'(push_i) - CW'(pop);
    head_d = head_q;
    if (cnt_d != '0)
      head_d = (push_i && (wr_q == rd_d)) ? din_i : mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
endmodule

module switch_nport #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int N_PORTS      = 4,
  parameter int DEPTH        = 4,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_vld,
  output logic                             in_rdy,
  input  logic [ADDR_WIDTH-1:0]            in_addr,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic [N_PORTS-1:0]               out_vld,
  input  logic [N_PORTS-1:0]               out_rdy,
  output logic [N_PORTS*ADDR_WIDTH-1:0]    out_addr,
  output logic [N_PORTS*DATA_WIDTH-1:0]    out_data,
  output logic [CNT_WIDTH-1:0]             drop_cnt
);
  localparam int SW = $clog2(N_PORTS);
  localparam int PW = ADDR_WIDTH + DATA_WIDTH;

  logic [SW-1:0]      sel;
  logic [N_PORTS-1:0] full;
  logic               acc, drop;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  assign sel    = in_addr[ADDR_WIDTH-1 -: SW];
  // Full is sampled before any same-cycle pop, so a full FIFO never takes a push.
  assign in_rdy = !rst && ((DROP_ON_FULL != 0) || !full[sel]);
  assign acc    = in_vld && in_rdy;
  assign drop   = acc && full[sel];

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [PW-1:0] head;

    switch_nport_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (acc && (sel == SW'(p)) && !full[p]),
      .din_i  ({in_addr, in_data}),
      .pop_i  (out_rdy[p]),
      .full_o (full[p]),
      .vld_o  (out_vld[p]),
      .head_o (head)
    );

    assign out_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = head[PW-1 -: ADDR_WIDTH];
    assign out_data[p*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
  end
endmodule

// File: tb/tb_switch_nport.sv
// Scoreboard bench: a blocking instance and a drop-mode instance share stimulus;
// one is monitored at a time against per-port expected queues.
module tb_switch_nport;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_vld = 0;
  logic [7:0]  in_addr = '0;
  logic [15:0] in_data = '0;
  logic [3:0]  out_rdy = 4'hF;

  logic        bp_rdy, dr_rdy;
  logic [3:0]  bp_vld, dr_vld;
  logic [31:0] bp_addr, dr_addr;
  logic [63:0] bp_data, dr_data;
  logic [15:0] bp_cnt;
  logic [3:0]  dr_cnt;

  switch_nport #(.DROP_ON_FULL(0)) u_bp (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(bp_rdy), .in_addr(in_addr),
    .in_data(in_data), .out_vld(bp_vld), .out_rdy(out_rdy), .out_addr(bp_addr),
    .out_data(bp_data), .drop_cnt(bp_cnt));

  switch_nport #(.DROP_ON_FULL(1), .CNT_WIDTH(4)) u_dr (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(dr_rdy), .in_addr(in_addr),
    .in_data(in_data), .out_vld(dr_vld), .out_rdy(out_rdy), .out_addr(dr_addr),
    .out_data(dr_data), .drop_cnt(dr_cnt));

  always #5 clk = ~clk;

  bit          mode = 0;
  bit          mon_en = 1;
  logic        act_rdy;
  logic [3:0]  act_vld;
  logic [31:0] act_addr;
  logic [63:0] act_data;
  logic [15:0] act_cnt;

  always_comb begin
    act_rdy  = mode ? dr_rdy  : bp_rdy;
    act_vld  = mode ? dr_vld  : bp_vld;
    act_addr = mode ? dr_addr : bp_addr;
    act_data = mode ? dr_data : bp_data;
    act_cnt  = mode ? {12'b0, dr_cnt} : bp_cnt;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef logic [23:0] ent_t;
  ent_t q [4][$];
  int   exp_cnt = 0;

  // Monitor: inputs are stable between edges, so the negedge sees what the next edge uses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        for (int p = 0; p < 4; p++) q[p].delete();
        exp_cnt = 0;
        chk("rst_in_rdy", {63'b0, act_rdy}, 64'd0);
      end else begin
        int  s;
        bit  full;
        ent_t e;
        s    = int'(in_addr[7:6]);
        full = (q[s].size() == DEPTH);
        chk("in_rdy", {63'b0, act_rdy}, {63'b0, (mode ? 1'b1 : !full)});
        chk("drop_cnt", {48'b0, act_cnt}, 64'(exp_cnt));
        for (int p = 0; p < 4; p++) begin
          chk("out_vld", {63'b0, act_vld[p]}, {63'b0, (q[p].size() != 0)});
          if (act_vld[p] && out_rdy[p] && q[p].size() != 0) begin
            e = q[p].pop_front();
            chk("out_addr", {56'b0, act_addr[p*8 +: 8]}, {56'b0, e[23:16]});
            chk("out_data", {48'b0, act_data[p*16 +: 16]}, {48'b0, e[15:0]});
          end
        end
        if (in_vld) begin
          if (!full) q[s].push_back({in_addr, in_data});
          else if (mode && exp_cnt < 15) exp_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [15:0] d);
    bit ok;
    int n;
    in_vld = 1; in_addr = a; in_data = d;
    n = 0;
    do begin
      @(negedge clk);
      ok = act_rdy;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 64'd1, 64'd0);
    in_vld = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rst(input bit m);
    rst = 1; mode = m; in_vld = 0; out_rdy = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    do_rst(0);
    @(negedge clk);
    chk("reset_vld",  {60'b0, act_vld}, 64'd0);
    chk("reset_cnt",  {48'b0, act_cnt}, 64'd0);
    chk("reset_rdy",  {63'b0, act_rdy}, 64'd1);
    chk("reset_addr", {32'b0, act_addr}, 64'd0);
    chk("reset_data", act_data, 64'd0);
    @(posedge clk); #1;

    // Routing on all four ports.
    send(8'h05, 16'h1111);
    send(8'h45, 16'h2222);
    send(8'h85, 16'h3333);
    send(8'hC5, 16'h4444);
    idle(4);
    chk("route_drained", {60'b0, act_vld}, 64'd0);

    // Backpressure on port 1; port 0 still accepted while port 1 is full.
    do_rst(0);
    out_rdy = 4'b1101;
    for (int i = 0; i < 4; i++) send(8'h40, 16'hA0 + 16'(i));
    in_vld = 1; in_addr = 8'h40; in_data = 16'hA4;
    repeat (2) begin
      @(negedge clk);
      chk("bp_full_rdy", {63'b0, act_rdy}, 64'd0);
    end
    @(posedge clk); #1;
    in_vld = 0;
    send(8'h00, 16'hB0);
    out_rdy = 4'hF;
    send(8'h40, 16'hA4);
    idle(8);
    chk("bp_drained", {60'b0, act_vld}, 64'd0);

    // Drop mode: 7 packets to a stalled port 2.
    do_rst(1);
    out_rdy = 4'b1011;
    for (int i = 0; i < 7; i++) send(8'h80, 16'hC0 + 16'(i));
    @(negedge clk);
    chk("drop_cnt_3", {48'b0, act_cnt}, 64'd3);
    @(posedge clk); #1;
    out_rdy = 4'hF;
    idle(6);
    chk("drop_drained", {60'b0, act_vld}, 64'd0);

    // Streaming 20 packets through port 0 with no stalls.
    do_rst(0);
    c0 = cyc;
    for (int i = 0; i < 20; i++) send(8'h00 + 8'(i), 16'(i));
    chk("stream_cycles", 64'(cyc - c0), 64'd20);
    idle(3);
    chk("stream_drained", {60'b0, act_vld}, 64'd0);

    // Drop counter saturation.
    do_rst(1);
    out_rdy = 4'b1110;
    for (int i = 0; i < 24; i++) send(8'h11, 16'h500 + 16'(i));
    @(negedge clk);
    chk("drop_sat", {48'b0, act_cnt}, 64'd15);
    @(posedge clk); #1;
    out_rdy = 4'hF;
    idle(6);

    // Reset mid-operation with a packet presented during the reset cycle.
    do_rst(1);
    out_rdy = 4'b0111;
    for (int i = 0; i < 5; i++) send(8'hC0, 16'hE0 + 16'(i));
    in_vld = 1; in_addr = 8'hC0; in_data = 16'hDEAD;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; in_vld = 0;
    @(negedge clk);
    chk("rst6_vld", {60'b0, act_vld}, 64'd0);
    chk("rst6_cnt", {48'b0, act_cnt}, 64'd0);
    chk("rst6_rdy", {63'b0, act_rdy}, 64'd1);
    @(posedge clk); #1;
    out_rdy = 4'hF;
    send(8'hC7, 16'h0600);
    idle(4);
    chk("rst6_drained", {60'b0, act_vld}, 64'd0);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
